// File: rtl/cnn_pkg.sv
// Shared definitions for the feature-map browsing blocks.
package cnn_pkg;

    localparam int DATA_SIZE = 8;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } nav_state_t;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse when a synchronous level goes 0 -> 1.
module edge_pulse (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic prev;

    // History resets to 1 so a level already high at reset release gives no pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/feature_nav.sv
// Button-driven browser over a flattened CHANNELS x SIZE x SIZE feature map,
// with a manual mode (saturating steps) and an auto-scan mode (wrapping steps).
module feature_nav #(
    parameter int CHANNELS  = 4,
    parameter int SIZE      = 5,
    parameter int DATA_SIZE = cnn_pkg::DATA_SIZE,
    parameter int TICK_DIV  = 50_000_000,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [CHANNELS*SIZE*SIZE*DATA_SIZE-1:0] fmap,
    input  logic                                   btn_next,
    input  logic                                   btn_prev,
    input  logic                                   btn_home,
    input  logic                                   btn_auto,
    output logic [CW-1:0]                          ch,
    output logic [PW-1:0]                          row,
    output logic [PW-1:0]                          col,
    output logic signed [DATA_SIZE-1:0]            value,
    output logic                                   changed,
    output logic                                   auto_on,
    output logic                                   at_first,
    output logic                                   at_last,
    output cnn_pkg::nav_state_t                    state_dbg
);

    import cnn_pkg::*;

    localparam int N  = CHANNELS * SIZE * SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] CH_MAX   = CW'(CHANNELS - 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(SIZE - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    logic next_p, prev_p, home_p, auto_p;

    edge_pulse u_next (.clk(clk), .reset_n(reset_n), .level(btn_next), .pulse(next_p));
    edge_pulse u_prev (.clk(clk), .reset_n(reset_n), .level(btn_prev), .pulse(prev_p));
    edge_pulse u_home (.clk(clk), .reset_n(reset_n), .level(btn_home), .pulse(home_p));
    edge_pulse u_auto (.clk(clk), .reset_n(reset_n), .level(btn_auto), .pulse(auto_p));

    nav_state_t      state, state_n;
    logic [CW-1:0]   ch_n, ch_f, ch_b;
    logic [PW-1:0]   row_n, row_f, row_b;
    logic [PW-1:0]   col_n, col_f, col_b;
    logic [TW-1:0]   tick, tick_n;
    logic            moved_q;
    logic            move;
    logic [IW-1:0]   flat;
    logic signed [DATA_SIZE-1:0] elem [N];

    assign at_first  = (ch == '0) && (row == '0) && (col == '0);
    assign at_last   = (ch == CH_MAX) && (row == POS_MAX) && (col == POS_MAX);
    assign auto_on   = (state == AUTO);
    assign state_dbg = state;

    // Forward and backward neighbours, both wrapping; carries are explicit compares.
    always_comb begin
        ch_f  = ch;
        row_f = row;
        col_f = col;
        if (col != POS_MAX) begin
            col_f = col + PW'(1);
        end else begin
            col_f = '0;
            if (row != POS_MAX) begin
                row_f = row + PW'(1);
            end else begin
                row_f = '0;
                ch_f  = (ch != CH_MAX) ? ch + CW'(1) : '0;
            end
        end
    end

    always_comb begin
        ch_b  = ch;
        row_b = row;
        col_b = col;
        if (col != '0) begin
            col_b = col - PW'(1);
        end else begin
            col_b = POS_MAX;
            if (row != '0) begin
                row_b = row - PW'(1);
            end else begin
                row_b = POS_MAX;
                ch_b  = (ch != '0) ? ch - CW'(1) : CH_MAX;
            end
        end
    end

    // Priority: home, then auto toggle, then a lone next/prev, then the scan tick.
    always_comb begin
        state_n = state;
        ch_n    = ch;
        row_n   = row;
        col_n   = col;
        tick_n  = tick;
        if (home_p) begin
            state_n = MANUAL;
            ch_n    = '0;
            row_n   = '0;
            col_n   = '0;
            tick_n  = '0;
        end else if (auto_p) begin
            state_n = (state == MANUAL) ? AUTO : MANUAL;
            tick_n  = '0;
        end else if (next_p ^ prev_p) begin
            if (state == AUTO) begin
                tick_n = '0;
                if (next_p) begin
                    ch_n = ch_f; row_n = row_f; col_n = col_f;
                end else begin
                    ch_n = ch_b; row_n = row_b; col_n = col_b;
                end
            end else if (next_p && !at_last) begin
                ch_n = ch_f; row_n = row_f; col_n = col_f;
            end else if (prev_p && !at_first) begin
                ch_n = ch_b; row_n = row_b; col_n = col_b;
            end
        end else if (state == AUTO) begin
            if (tick == TICK_MAX) begin
                tick_n = '0;
                ch_n = ch_f; row_n = row_f; col_n = col_f;
            end else begin
                tick_n = tick + TW'(1);
            end
        end
    end

    assign move = (ch_n != ch) || (row_n != row) || (col_n != col);

    always_comb begin
        for (int e = 0; e < N; e++) begin
            elem[e] = fmap[e*DATA_SIZE +: DATA_SIZE];
        end
        flat = IW'(ch) * IW'(SIZE * SIZE) + IW'(row) * IW'(SIZE) + IW'(col);
    end

    // moved_q resets high so the first cycle after release reports the initial value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MANUAL;
            ch      <= '0;
            row     <= '0;
            col     <= '0;
            tick    <= '0;
            moved_q <= 1'b1;
            value   <= '0;
            changed <= 1'b0;
        end else begin
            state   <= state_n;
            ch      <= ch_n;
            row     <= row_n;
            col     <= col_n;
            tick    <= tick_n;
            moved_q <= move;
            value   <= elem[flat];
            changed <= moved_q;
        end
    end

endmodule

// File: tb/tb_feature_nav.sv
// Directed bench for feature_nav: 2 channels of 3x3, element e holds e+1.
module tb_feature_nav;

    localparam int CHANNELS  = 2;
    localparam int SIZE      = 3;
    localparam int DATA_SIZE = 8;
    localparam int TICK_DIV  = 4;

    logic                                    clk;
    logic                                    reset_n;
    logic [CHANNELS*SIZE*SIZE*DATA_SIZE-1:0] fmap;
    logic                                    btn_next, btn_prev, btn_home, btn_auto;
    logic [0:0]                              ch;
    logic [1:0]                              row, col;
    logic signed [DATA_SIZE-1:0]             value;
    logic                                    changed, auto_on, at_first, at_last;
    cnn_pkg::nav_state_t                     state_dbg;

    int n_cmp;
    int n_bad;

    feature_nav #(
        .CHANNELS (CHANNELS),
        .SIZE     (SIZE),
        .DATA_SIZE(DATA_SIZE),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .fmap     (fmap),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .btn_home (btn_home),
        .btn_auto (btn_auto),
        .ch       (ch),
        .row      (row),
        .col      (col),
        .value    (value),
        .changed  (changed),
        .auto_on  (auto_on),
        .at_first (at_first),
        .at_last  (at_last),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx();
        return int'(ch) * 9 + int'(row) * 3 + int'(col);
    endfunction

    task automatic press_next();
        btn_next = 1'b1; step(); btn_next = 1'b0; step();
    endtask

    task automatic press_prev();
        btn_prev = 1'b1; step(); btn_prev = 1'b0; step();
    endtask

    task automatic press_home();
        btn_home = 1'b1; step(); btn_home = 1'b0; step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int e = 0; e < CHANNELS*SIZE*SIZE; e++) begin
            fmap[e*DATA_SIZE +: DATA_SIZE] = 8'(e + 1);
        end
        btn_next = 1'b0; btn_prev = 1'b0; btn_home = 1'b0; btn_auto = 1'b0;
        reset_n  = 1'b0;
        repeat (3) step();
        check_eq("rst_idx", idx(), 0);
        check_eq("rst_value", int'(value), 0);
        check_eq("rst_changed", int'(changed), 0);
        check_eq("rst_auto", int'(auto_on), 0);

        reset_n = 1'b1;
        #1;
        check_eq("rel_idx", idx(), 0);
        step();
        check_eq("first_value", int'(value), 1);
        check_eq("first_changed", int'(changed), 1);
        step();
        check_eq("first_changed_drop", int'(changed), 0);

        // three steps forward, then a held button
        press_next(); press_next(); press_next();
        check_eq("next3_row", int'(row), 1);
        check_eq("next3_col", int'(col), 0);
        check_eq("next3_value", int'(value), 4);
        check_eq("next3_changed", int'(changed), 1);
        btn_next = 1'b1;
        repeat (10) step();
        btn_next = 1'b0;
        step();
        check_eq("held_idx", idx(), 4);
        check_eq("held_value", int'(value), 5);

        // saturation at both ends in MANUAL
        press_home();
        check_eq("home_idx", idx(), 0);
        check_eq("home_value", int'(value), 1);
        btn_prev = 1'b1; step();
        check_eq("prev0_idx", idx(), 0);
        check_eq("prev0_first", int'(at_first), 1);
        btn_prev = 1'b0; step();
        check_eq("prev0_changed", int'(changed), 0);
        repeat (17) press_next();
        check_eq("walk_ch", int'(ch), 1);
        check_eq("walk_row", int'(row), 2);
        check_eq("walk_col", int'(col), 2);
        check_eq("walk_value", int'(value), 18);
        check_eq("walk_last", int'(at_last), 1);
        press_next();
        check_eq("sat_idx", idx(), 17);
        check_eq("sat_value", int'(value), 18);
        check_eq("sat_changed", int'(changed), 0);

        // auto scan wraps 17 -> 0 on the 4th edge after entry
        btn_auto = 1'b1; step(); btn_auto = 1'b0;
        check_eq("auto_on", int'(auto_on), 1);
        check_eq("auto_state", int'(state_dbg), int'(cnn_pkg::AUTO));
        repeat (3) step();
        check_eq("auto_wait_idx", idx(), 17);
        step();
        check_eq("auto_wrap_idx", idx(), 0);
        step();
        check_eq("auto_wrap_value", int'(value), 1);
        check_eq("auto_wrap_changed", int'(changed), 1);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        check_eq("auto_next_idx", idx(), 1);
        repeat (3) step();
        check_eq("auto_restart_idx", idx(), 1);
        step();
        check_eq("auto_tick_idx", idx(), 2);

        // back to MANUAL, then simultaneous buttons
        btn_auto = 1'b1; step(); btn_auto = 1'b0;
        check_eq("manual_again", int'(auto_on), 0);
        check_eq("manual_idx", idx(), 2);
        step();
        btn_next = 1'b1; btn_prev = 1'b1; step();
        btn_next = 1'b0; btn_prev = 1'b0; step();
        check_eq("np_idx", idx(), 2);
        check_eq("np_changed", int'(changed), 0);
        btn_home = 1'b1; btn_auto = 1'b1; step();
        btn_home = 1'b0; btn_auto = 1'b0;
        check_eq("ha_idx", idx(), 0);
        check_eq("ha_auto", int'(auto_on), 0);
        step();

        // reset in the middle of an auto scan, with next held across release
        btn_auto = 1'b1; step(); btn_auto = 1'b0;
        repeat (4) step();
        check_eq("scan_idx", idx(), 1);
        btn_next = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("arst_idx", idx(), 0);
        check_eq("arst_value", int'(value), 0);
        check_eq("arst_auto", int'(auto_on), 0);
        check_eq("arst_changed", int'(changed), 0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();
        check_eq("held_rel_idx", idx(), 0);
        check_eq("held_rel_auto", int'(auto_on), 0);
        btn_next = 1'b0;
        step();
        press_next();
        check_eq("post_rst_idx", idx(), 1);
        check_eq("post_rst_value", int'(value), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/feature_nav.md
FEATURE_NAV -- requirements
Module: feature_nav

Interface
REQ-001 Parameter CHANNELS, default 4: channel count of the browsed feature map.
REQ-002 Parameter SIZE, default 5: rows and cols per channel (square map).
REQ-003 Parameter DATA_SIZE, default 8: signed element width.
REQ-004 Parameter TICK_DIV, default 50_000_000: clk cycles per auto-scan step; legal range is 2 or more.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 fmap  in  CHANNELS*SIZE*SIZE*DATA_SIZE  flattened map; element e = c*SIZE*SIZE + r*SIZE + k occupies bits [e*DATA_SIZE +: DATA_SIZE].
REQ-008 btn_next, btn_prev, btn_home, btn_auto  in  1 each  debounced button levels, synchronous to clk.
REQ-009 ch  out  $clog2(CHANNELS) (min 1)  selected channel.
REQ-010 row, col  out  $clog2(SIZE) (min 1) each  selected position.
REQ-011 value  out  DATA_SIZE  signed registered fmap element at (ch,row,col).
REQ-012 changed  out  1  one-cycle pulse with each value update.
REQ-013 auto_on  out  1  high in AUTO state.
REQ-014 at_first, at_last  out  1 each  combinational flags: index == 0, index == last (CHANNELS*SIZE*SIZE-1).

Function
REQ-015 Each button SHALL be rising-edge detected; a pulse is high in the cycle where level=1 and the previous sample was 0; a held button SHALL produce exactly one pulse.
REQ-016 Index order SHALL be col fastest, then row, then ch; a step forward from (c,SIZE-1,SIZE-1) goes to (c+1,0,0).
REQ-017 ch/row/col SHALL update on the clk edge that samples the pulse; value and changed SHALL follow one cycle later.
REQ-018 Priority in one cycle: home > auto toggle > next/prev; next and prev together SHALL cause no move.
REQ-019 home pulse SHALL set index 0 and force state MANUAL.
REQ-020 FSM states: MANUAL, AUTO; auto pulse toggles MANUAL<->AUTO; entering AUTO clears the tick counter.
REQ-021 MANUAL: next at last and prev at 0 SHALL saturate (no move, no changed pulse).
REQ-022 AUTO: tick counter counts 0..TICK_DIV-1; at terminal count index advances by one, wrapping last->0.
REQ-023 AUTO: next/prev pulses SHALL move with wrap-around and restart the tick counter at 0.
REQ-024 changed SHALL pulse only when the index actually changes or on the first cycle after reset release; value SHALL always track fmap at the registered index, without a pulse if fmap changes alone.
REQ-025 No arithmetic overflow: row/col/ch carries SHALL be explicit compares against SIZE-1 and CHANNELS-1.

Reset
REQ-026 reset_n low SHALL asynchronously force ch=row=col=0, value=0, changed=0, state MANUAL, tick counter 0, edge-detector history 1, so buttons held during reset produce no pulse.
REQ-027 Reset asserted mid-auto-scan SHALL abort the scan; operation resumes in MANUAL at index 0.

Structure
REQ-028 The shared package cnn_pkg SHALL hold DATA_SIZE and the nav state enum (MANUAL, AUTO).
REQ-029 One sub-module edge_pulse (level in, one-cycle pulse out, async active-low reset) SHALL be instantiated per button.

Verification (CHANNELS=2, SIZE=3, DATA_SIZE=8, TICK_DIV=4, fmap element e = e+1)
REQ-030 Release reset -> ch/row/col=0; one cycle later value=1, changed=1.
REQ-031 Three next presses -> (0,1,0), value=4; next held 10 cycles -> exactly one step.
REQ-032 Home, then prev -> index unchanged, at_first=1, no changed pulse; walk to 17 and press next -> stays (1,2,2), value=18, at_last=1.
REQ-033 Auto at index 17 -> after 4 cycles index 0, value=1; next after 4 more cycles -> index 1 and step timing restarts.
REQ-034 Next and prev in same cycle -> no move; home and auto together -> index 0, auto_on=0.
REQ-035 Drop reset_n mid-AUTO -> immediate zeroed outputs, auto_on=0, no pulse from buttons held across release.
